// File: rtl/addsub_seq.sv
// addsub_seq: operand/result controller wrapped around a 3-bit adder/subtractor.
// Ports: in_* accept handshake, au_* adder drive/return, out_* result handshake + flags.
module addsub_seq #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_a,
   input  logic [2:0] in_b,
   input  logic       in_sub,
   output logic [2:0] au_a,
   output logic [2:0] au_b,
   output logic       au_s,
   input  logic [2:0] au_sum,
   input  logic       au_carry,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_sum,
   output logic       out_carry,
   output logic       out_ovf,
   output logic       out_zero,
   output logic       out_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   generate
      if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
         $error("addsub_seq: SETTLE must be in 1..15");
      end
   endgenerate

   logic [1:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] a_q, a_d;
   logic [2:0] b_q, b_d;
   logic       sub_q, sub_d;
   logic       valid_q, valid_d;
   logic [2:0] sum_q, sum_d;
   logic       carry_q, carry_d;
   logic       ovf_q, ovf_d;
   logic       zero_q, zero_d;
   logic       err_q, err_d;

   logic [2:0] beff;
   logic [3:0] ref_res;

   // Reference result built from the registered operands, so it always
   // matches what is currently driven onto the adder.
   always_comb begin
      beff    = sub_q ? ~b_q : b_q;
      ref_res = {1'b0, a_q} + {1'b0, beff} + {3'b000, sub_q};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      valid_d = valid_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               sub_d   = in_sub;
               cnt_d   = CNT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               sum_d   = au_sum;
               carry_d = au_carry;
               ovf_d   = (a_q[2] == beff[2]) && (au_sum[2] != a_q[2]);
               zero_d  = (au_sum == 3'b000);
               if ({au_carry, au_sum} != ref_res) begin
                  err_d = 1'b1;
               end
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         a_q     <= 3'd0;
         b_q     <= 3'd0;
         sub_q   <= 1'b0;
         valid_q <= 1'b0;
         sum_q   <= 3'd0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         valid_q <= valid_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign au_a      = a_q;
   assign au_b      = b_q;
   assign au_s      = sub_q;
   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_carry = carry_q;
   assign out_ovf   = ovf_q;
   assign out_zero  = zero_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: scoreboard bench for addsub_seq with a behavioural
// adder/subtractor model that can inject a wrong sum for 1+1.
module tb_addsub_seq;

   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_a = 3'd0;
   logic [2:0] in_b = 3'd0;
   logic       in_sub = 1'b0;
   logic [2:0] au_a;
   logic [2:0] au_b;
   logic       au_s;
   logic [2:0] au_sum;
   logic       au_carry;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] out_sum;
   logic       out_carry;
   logic       out_ovf;
   logic       out_zero;
   logic       out_err;

   logic       fault_en = 1'b0;
   logic       exp_err = 1'b0;
   int         n_tests = 0;
   int         n_fail = 0;

   typedef struct {
      logic [2:0] sum;
      logic       carry;
      logic       ovf;
      logic       zero;
      logic       err;
   } exp_t;

   exp_t sb[$];

   addsub_seq #(.SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .au_a(au_a), .au_b(au_b), .au_s(au_s),
      .au_sum(au_sum), .au_carry(au_carry),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_carry(out_carry),
      .out_ovf(out_ovf), .out_zero(out_zero), .out_err(out_err)
   );

   always #5 clk = ~clk;

   // Adder/subtractor model: subtract carry means "no borrow".
   always_comb begin
      if (au_s) begin
         au_sum   = au_a - au_b;
         au_carry = (au_a >= au_b);
      end else begin
         {au_carry, au_sum} = {1'b0, au_a} + {1'b0, au_b};
      end
      if (fault_en && !au_s && au_a == 3'd1 && au_b == 3'd1) begin
         au_sum = 3'd6;
      end
   end

   function automatic exp_t model(input logic [2:0] a, input logic [2:0] b,
                                  input logic s, input logic flt);
      exp_t e;
      int ai, bi, r;
      logic [2:0] ref_sum, got;
      ai = int'(a);
      bi = int'(b);
      if (s) begin
         r = (ai - bi + 8) % 8;
         e.carry = (ai >= bi);
      end else begin
         r = (ai + bi) % 8;
         e.carry = (ai + bi) > 7;
      end
      ref_sum = 3'(r);
      got = (flt && !s && a == 3'd1 && b == 3'd1) ? 3'd6 : ref_sum;
      e.sum = got;
      if (s) e.ovf = (a[2] != b[2]) && (got[2] != a[2]);
      else   e.ovf = (a[2] == b[2]) && (got[2] != a[2]);
      e.zero = (got == 3'd0);
      e.err = exp_err | (got != ref_sum);
      return e;
   endfunction

   task automatic run_op(input logic [2:0] a, input logic [2:0] b,
                         input logic s, input int stall);
      exp_t e;
      int lat;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready got %b want 1", in_ready);
      end
      in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
      out_ready = (stall == 0);
      sb.push_back(model(a, b, s, fault_en));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 3'($urandom); in_b = 3'($urandom); in_sub = 1'($urandom);
      n_tests++;
      if ({au_a, au_b, au_s, in_ready} !== {a, b, s, 1'b0}) begin
         n_fail++;
         $display("FAIL au_drive got %h/%h/%b rdy=%b want %h/%h/%b rdy=0",
                  au_a, au_b, au_s, in_ready, a, b, s);
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      n_tests++;
      if (lat != SETTLE) begin
         n_fail++;
         $display("FAIL latency got %0d want %0d", lat, SETTLE);
      end
      e = sb.pop_front();
      exp_err = e.err;
      for (int i = 0; i < stall; i++) begin
         in_valid = i[0];
         in_a = 3'($urandom); in_b = 3'($urandom);
         n_tests++;
         if ({out_valid, in_ready, out_sum, out_carry, out_ovf, out_zero} !==
             {2'b10, e.sum, e.carry, e.ovf, e.zero}) begin
            n_fail++;
            $display("FAIL hold_stable cyc %0d got v=%b r=%b s=%0d c=%b want s=%0d c=%b",
                     i, out_valid, in_ready, out_sum, out_carry, e.sum, e.carry);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_tests++;
      if ({out_sum, out_carry, out_ovf, out_zero, out_err} !==
          {e.sum, e.carry, e.ovf, e.zero, e.err}) begin
         n_fail++;
         $display("FAIL result %h-%h-%b got s=%0d c=%b o=%b z=%b e=%b want s=%0d c=%b o=%b z=%b e=%b",
                  a, b, s, out_sum, out_carry, out_ovf, out_zero, out_err,
                  e.sum, e.carry, e.ovf, e.zero, e.err);
      end
      n_tests++;
      if ({au_a, au_b, au_s} !== {a, b, s}) begin
         n_fail++;
         $display("FAIL operand_hold got %h/%h/%b want %h/%h/%b",
                  au_a, au_b, au_s, a, b, s);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_tests++;
      if ({out_valid, in_ready, out_sum, out_carry} !== {2'b01, e.sum, e.carry}) begin
         n_fail++;
         $display("FAIL complete got v=%b r=%b s=%0d c=%b want v=0 r=1 s=%0d c=%b",
                  out_valid, in_ready, out_sum, out_carry, e.sum, e.carry);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({in_ready, out_valid, out_err, out_sum, out_carry, out_ovf,
           out_zero, au_a, au_b, au_s} !== 16'h8000) begin
         n_fail++;
         $display("FAIL reset_vals got r=%b v=%b e=%b s=%0d a=%0d b=%0d",
                  in_ready, out_valid, out_err, out_sum, au_a, au_b);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      run_op(3'd5, 3'd3, 1'b0, 0);
      run_op(3'd3, 3'd2, 1'b0, 0);
      run_op(3'd6, 3'd7, 1'b0, 1);
   endtask

   task automatic test_sub;
      run_op(3'd2, 3'd3, 1'b1, 0);
      run_op(3'd4, 3'd1, 1'b1, 2);
      run_op(3'd5, 3'd5, 1'b1, 0);
   endtask

   task automatic test_backpressure;
      run_op(3'd3, 3'd4, 1'b1, 10);
   endtask

   task automatic test_fault;
      fault_en = 1'b1;
      run_op(3'd1, 3'd1, 1'b0, 0);
      fault_en = 1'b0;
      run_op(3'd2, 3'd1, 1'b0, 0);
      run_op(3'd3, 3'd3, 1'b1, 0);
   endtask

   task automatic test_reset_abort;
      in_a = 3'd2; in_b = 3'd1; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_err = 1'b0;
      #1;
      n_tests++;
      if ({in_ready, out_valid, out_err, out_sum, out_carry, out_ovf,
           out_zero, au_a, au_b, au_s} !== 16'h8000) begin
         n_fail++;
         $display("FAIL abort_reset got r=%b v=%b e=%b s=%0d a=%0d b=%0d",
                  in_ready, out_valid, out_err, out_sum, au_a, au_b);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_valid cyc %0d got %b want 0", i, out_valid);
         end
      end
      run_op(3'd6, 3'd7, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_fault();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Sequential operand/result controller that sits directly upstream and downstream of the 3-bit adder/subtractor. It accepts an operation through a valid/ready handshake and drives the operands and mode onto the adder/subtractor's inputs. It waits a programmable settle time, captures the sum and carry, and derives status flags. It also checks the captured result against an internal reference and presents it through a second valid/ready handshake.

## Interface
- SETTLE, 2: cycles the operands are held before the result is sampled; legal range 1..15; 0 is illegal and a compile-time error.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low; all state returns to reset values immediately.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- in_a  in  3  operand A (bit 2 = MSB, two's complement).
- in_b  in  3  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- au_a  out  3  drives A3..A1 of the adder/subtractor.
- au_b  out  3  drives B3..B1 of the adder/subtractor.
- au_s  out  1  drives S (mode) of the adder/subtractor.
- au_sum  in  3  S3..S1 returned by the adder/subtractor.
- au_carry  in  1  Carry returned by the adder/subtractor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  3  captured sum.
- out_carry  out  1  captured carry; in subtract mode, 1 = no borrow.
- out_ovf  out  1  signed overflow of the operation.
- out_zero  out  1  out_sum == 0.
- out_err  out  1  sticky mismatch flag: the adder/subtractor result differed from the internal reference.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid=1, register in_a/in_b/in_sub into the operand registers, load cnt=SETTLE−1 and go to WAIT.
  - WAIT: in_ready=0. Decrement cnt each cycle. When cnt==0, capture au_sum/au_carry, compute flags, set out_valid=1 and go to HOLD.
  - HOLD: in_ready=0 and out_valid=1. When out_ready=1, clear out_valid and go to IDLE.
- Only one operation is in flight; there is no pipelining or overlap.
- au_a, au_b and au_s come straight from the operand registers and stay stable from accept until the next accept.
- Internal reference, computed in 4 bits:
  - beff = in_sub ? ~b : b.
  - r = a + beff + in_sub.
  - exp_sum = r[2:0], exp_carry = r[3].
- Flags:
  - out_ovf = (a[2]==beff[2]) && (au_sum[2]!=a[2]).
  - out_zero = (au_sum==3'b000).
  - out_ovf and out_zero are computed from the captured au_sum, not from the reference.
- out_err is set at capture if {au_carry,au_sum} != {exp_carry,exp_sum}. It stays set until reset and is never cleared by a handshake.
- Unknown or illegal state encodings recover to IDLE on the next clock.

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - out_valid=0, out_err=0.
  - out_sum=0, out_carry=0, out_ovf=0, out_zero=0.
  - au_a=0, au_b=0, au_s=0.
  - cnt=0.
- Handshakes:
  - Accept occurs on a rising edge with in_valid && in_ready.
  - Completion occurs on a rising edge with out_valid && out_ready.
- Latency:
  - With accept at edge T, the capture happens and out_valid rises at edge T+SETTLE.
  - The earliest completion is at edge T+SETTLE+1; the next accept is possible at edge T+SETTLE+2.
- With SETTLE=1, WAIT lasts one cycle: capture occurs at the first edge in WAIT.
- Holding out_ready=1 in advance does not shorten latency: out_valid is still high for at least one cycle.
- out_* outputs are stable while out_valid=1 and keep their last value after completion until the next capture.
- in_valid asserted while in_ready=0 is ignored; the input holds its request until accepted.
- Reset asserted mid-WAIT or mid-HOLD aborts the operation. No out_valid is produced for it, and outputs return to reset values asynchronously.

## Test plan
- Reset, then a=5, b=3, sub=0, SETTLE=2, with a correct model -> out_valid exactly 2 cycles after accept; sum=0, carry=1, ovf=0, zero=1, err=0.
- a=3, b=2, sub=0 -> sum=5, carry=0, ovf=1, zero=0.
- a=2, b=3, sub=1 -> au_s=1 during WAIT; sum=7, carry=0 (borrow), ovf=0. Then a=4, b=1, sub=1 -> sum=3, carry=1, ovf=1.
- out_ready held low for 10 cycles -> out_valid and out_* stay constant, in_ready=0, and a pulsing in_valid is ignored. Release out_ready -> in_ready=1 on the next cycle.
- Fault model returns au_sum=6 for 1+1 -> out_err=1 and stays 1 through further correct operations until rst_n goes low.
- rst_n pulsed low one cycle after accept -> no out_valid for that operation, all outputs at reset values, and the next operation completes normally.
